// File: rtl/lpf_pkg.sv
// Shared sample types for the low-pass filter and decimating FIFO.
// Optional build macro: LPF_DEC_AVG_EN (see lpf_dec_fifo).
package lpf_pkg;
  localparam int SAMPLE_W = 12;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/lpf_sync_fifo.sv
// Synchronous FIFO with registered head output and sticky overflow.
// Full/empty come from the occupancy count, never from pointer equality.
module lpf_sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop_req,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    nxt_rd;
  logic             full;
  logic             pop;
  logic             wr_ok;

  assign valid  = (level != '0);
  assign full   = (level == LW'(DEPTH));
  assign pop    = valid & pop_req;
  assign wr_ok  = push & (~full | pop);
  assign nxt_rd = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (wr_ok && !clr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rdata    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rdata    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= nxt_rd;
      unique case ({wr_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
      // Head register tracks the entry that will be oldest next cycle.
      if (pop) begin
        if (level == LW'(1)) begin
          if (wr_ok) rdata <= wdata;
        end else begin
          rdata <= mem[nxt_rd];
        end
      end else if (!valid && wr_ok) begin
        rdata <= wdata;
      end
    end
  end
endmodule

// File: rtl/lpf_dec_fifo.sv
// Strobe-aligned capture and decimation of filter output into a FIFO.
// Define LPF_DEC_AVG_EN to push the block average instead of every DEC-th sample.
module lpf_dec_fifo
  import lpf_pkg::*;
#(
  parameter int DEC   = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   f_s,
  input  sample_t                din,
  output sample_t                m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);
  localparam int CW = $clog2(DEC);

  logic          p0;
  logic          p1;
  logic          cap;
  logic          edge_s;
  logic [CW-1:0] cnt;
  logic          step;
  logic          last;
  logic          push;
  sample_t       push_val;

  assign edge_s = p0 & ~p1;
  assign step   = cap & en;
  assign last   = (cnt == CW'(DEC - 1));
  assign push   = step & last & ~clr;

  // cap trails the upstream edge so din has settled in its register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0  <= 1'b0;
      p1  <= 1'b0;
      cap <= 1'b0;
      cnt <= '0;
    end else begin
      p0  <= f_s;
      p1  <= p0;
      cap <= edge_s;
      if (clr)       cnt <= '0;
      else if (step) cnt <= last ? '0 : cnt + CW'(1);
    end
  end

`ifdef LPF_DEC_AVG_EN
  logic signed [SAMPLE_W+CW-1:0] acc;
  logic signed [SAMPLE_W+CW-1:0] acc_sum;

  assign acc_sum  = acc + (SAMPLE_W+CW)'(din);
  assign push_val = sample_t'(acc_sum >>> CW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      acc <= '0;
    else if (clr)  acc <= '0;
    else if (step) acc <= last ? '0 : acc_sum;
  end
`else
  assign push_val = din;
`endif

  lpf_sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .push     (push),
    .wdata    (push_val),
    .pop_req  (m_ready),
    .rdata    (m_data),
    .valid    (m_valid),
    .level    (level),
    .overflow (overflow)
  );
endmodule
